decoder_2x4_pipe: RTL and testbench

Streaming binary-to-one-hot decoder, the inverse of the team's 4-to-2 encoder. It accepts N-bit codes over a valid/ready handshake and decodes each one to a 2^N-bit one-hot word. Results are buffered in a 2-entry FIFO and presented over a downstream valid/ready handshake. Per-line saturating hit counters are kept for debug and readback. It sits between a code producer and any one-hot consumer, such as select lines or a demux.

---
 rtl/decoder_2x4_pipe_pkg.sv | 18 +
 rtl/decoder_2x4_pipe_if.sv | 30 +++
 rtl/decoder_2x4_pipe_skid_fifo2.sv | 62 ++++++
 rtl/decoder_2x4_pipe.sv | 62 ++++++
 tb/tb_decoder_2x4_pipe.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/decoder_2x4_pipe_pkg.sv
// Shared definitions for the streaming decoder/demux family.
// onehot_dec works at a fixed maximum width; callers cast to their own M.
package decoder_pkg;

    localparam int N_DEF     = 2;
    localparam int CNT_W_DEF = 8;
    localparam int N_MAX     = 6;
    localparam int M_MAX     = 2**N_MAX;

    function automatic logic [M_MAX-1:0] onehot_dec(input logic [N_MAX-1:0] code,
                                                    input logic             en);
        logic [M_MAX-1:0] word;
        word = '0;
        if (en) word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/decoder_2x4_pipe_if.sv
// Producer/consumer/debug bundle of the streaming decoder.
// master = code producer and word consumer, slave = decoder block.
interface decoder_2x4_pipe_if #(
    parameter int N     = decoder_pkg::N_DEF,
    parameter int CNT_W = decoder_pkg::CNT_W_DEF
);
    localparam int M = 2**N;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_code;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     out_onehot;
    logic [N-1:0]     cnt_sel;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_clr;

    modport master (
        output in_valid, in_code, in_en, out_ready, cnt_sel, cnt_clr,
        input  in_ready, out_valid, out_onehot, cnt_val
    );

    modport slave (
        input  in_valid, in_code, in_en, out_ready, cnt_sel, cnt_clr,
        output in_ready, out_valid, out_onehot, cnt_val
    );

endinterface

// File: rtl/decoder_2x4_pipe_skid_fifo2.sv
// Generic 2-entry FIFO, valid/ready on both sides, no write-to-read bypass.
// The read data is forced to zero while the FIFO is empty.
module skid_fifo2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid_i,
    output logic         wr_ready_o,
    input  logic [W-1:0] wr_data_i,
    output logic         rd_valid_o,
    input  logic         rd_ready_i,
    output logic [W-1:0] rd_data_o
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    // ready is masked by rst so nothing is offered while reset is held
    assign wr_ready_o = !rst && (count_q != 2'd2);
    assign rd_valid_o = (count_q != 2'd0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = rd_valid_o && rd_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/decoder_2x4_pipe.sv
// Streaming binary-to-one-hot decoder: decode at write, 2-entry FIFO,
// per-line saturating hit counters with combinational readback.
module decoder_2x4_pipe
    import decoder_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    decoder_2x4_pipe_if.slave bus
);

    localparam int             M       = 2**N;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [M-1:0]     wr_word;
    logic [M-1:0]     rd_word;
    logic             rd_valid;
    logic             rd_fire;
    logic [CNT_W-1:0] cnt_arr [M];

    assign wr_word = M'(onehot_dec(N_MAX'(bus.in_code), bus.in_en));

    skid_fifo2 #(.W(M)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (bus.in_valid),
        .wr_ready_o (bus.in_ready),
        .wr_data_i  (wr_word),
        .rd_valid_o (rd_valid),
        .rd_ready_i (bus.out_ready),
        .rd_data_o  (rd_word)
    );

    assign bus.out_valid  = rd_valid;
    assign bus.out_onehot = rd_word;
    assign rd_fire        = rd_valid && bus.out_ready;

    for (genvar i = 0; i < M; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // clear wins over a same-cycle delivery
        always_comb begin
            cnt_d = cnt_q;
            if (bus.cnt_clr)
                cnt_d = '0;
            else if (rd_fire && rd_word[i] && (cnt_q != CNT_MAX))
                cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end

        assign cnt_arr[i] = cnt_q;
    end

    assign bus.cnt_val = cnt_arr[bus.cnt_sel];

endmodule

// File: tb/tb_decoder_2x4_pipe.sv
// Bench for decoder_2x4_pipe: directed scenarios plus random traffic,
// checked every cycle against a queue/array reference model.
module tb_decoder_2x4_pipe;

    localparam int N     = 2;
    localparam int CNT_W = 2;
    localparam int M     = 4;
    localparam int CMAX  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoder_2x4_pipe_if #(.N(N), .CNT_W(CNT_W)) bus ();

    decoder_2x4_pipe #(.N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int cnt_m[M];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle from a falling edge: drive, check, let the edge happen, update model.
    task automatic cyc(input bit iv, input int code, input bit en, input bit ordy,
                       input bit clr, output bit acc);
        bit del;
        int w;
        bus.in_valid  = iv;
        bus.in_code   = code[1:0];
        bus.in_en     = en;
        bus.out_ready = ordy;
        bus.cnt_clr   = clr;
        bus.cnt_sel   = 2'($urandom_range(0, M-1));
        #1;
        chk("out_valid",  bus.out_valid,  exp_q.size() != 0);
        chk("out_onehot", bus.out_onehot, exp_q.size() != 0 ? exp_q[0] : 0);
        chk("in_ready",   bus.in_ready,   exp_q.size() < 2);
        chk("cnt_val",    bus.cnt_val,    cnt_m[bus.cnt_sel]);
        acc = iv && (exp_q.size() < 2);
        del = ordy && (exp_q.size() != 0);
        w   = 0;
        @(posedge clk);
        if (del) w = exp_q.pop_front();
        if (clr) begin
            foreach (cnt_m[i]) cnt_m[i] = 0;
        end else if (del) begin
            for (int i = 0; i < M; i++)
                if (w == (1 << i) && cnt_m[i] < CMAX) cnt_m[i]++;
        end
        if (acc) exp_q.push_back(en ? (1 << code) : 0);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.cnt_clr   = 1'b0;
        for (int s = 0; s < M; s++) begin
            bus.cnt_sel = s[1:0];
            #1;
            chk(tag, bus.cnt_val, cnt_m[s]);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bit a;
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) cyc(0, 0, 0, 1, 0, a);
        chk("drain_empty", bus.out_valid, 1'b0);
    endtask

    initial begin
        bit a, pend, tog;
        int pc, tries;
        bit pe;
        bus.in_valid = 0; bus.in_code = 0; bus.in_en = 0;
        bus.out_ready = 0; bus.cnt_sel = 0; bus.cnt_clr = 0;
        foreach (cnt_m[i]) cnt_m[i] = 0;

        #2;
        chk("rst_in_ready",   bus.in_ready,   1'b0);
        chk("rst_out_valid",  bus.out_valid,  1'b0);
        chk("rst_out_onehot", bus.out_onehot, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single code 2, consumer ready
        cyc(1, 2, 1, 1, 0, a);
        chk("first_accept", a, 1'b1);
        cyc(0, 0, 0, 1, 0, a);
        check_all("cnt_single");

        // backpressure: two absorbed, then drained in order
        cyc(1, 0, 1, 0, 0, a);
        cyc(1, 3, 1, 0, 0, a);
        cyc(0, 0, 0, 0, 0, a);
        cyc(0, 0, 0, 1, 0, a);
        cyc(0, 0, 0, 1, 0, a);
        cyc(0, 0, 0, 0, 0, a);

        // disabled entry decodes to zero, counters untouched
        cyc(1, 1, 0, 1, 0, a);
        cyc(0, 0, 0, 1, 0, a);
        check_all("cnt_disabled");

        // streaming, consumer always ready
        cyc(0, 0, 0, 0, 1, a);
        for (int i = 0; i < 8; i++) cyc(1, i % 4, 1, 1, 0, a);
        drain();
        check_all("cnt_stream");

        // streaming, consumer toggling every cycle
        cyc(0, 0, 0, 0, 1, a);
        tog = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 1'b0;
            for (tries = 0; tries < 10 && !a; tries++) begin
                cyc(1, i % 4, 1, tog, 0, a);
                tog = ~tog;
            end
            chk("toggle_accept", a, 1'b1);
        end
        drain();
        check_all("cnt_toggle");

        // saturation, then clear racing a delivery
        cyc(0, 0, 0, 0, 1, a);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0, a);
        drain();
        check_all("cnt_sat");
        cyc(1, 1, 1, 0, 0, a);
        cyc(0, 0, 0, 1, 1, a);
        check_all("cnt_clr_race");

        // random traffic with producer hold rule respected
        pend = 1'b0; pc = 0; pe = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bit iv;
            if (pend) iv = 1'b1;
            else begin
                iv = ($urandom_range(0, 3) != 0);
                pc = $urandom_range(0, 3);
                pe = ($urandom_range(0, 5) != 0);
            end
            cyc(iv, pc, pe, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), a);
            pend = iv && !a;
        end

        // asynchronous reset with a full FIFO
        drain();
        cyc(1, 2, 1, 1, 0, a);
        cyc(1, 0, 1, 0, 0, a);
        cyc(1, 3, 1, 0, 0, a);
        chk("full_before_rst", bus.in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid",  bus.out_valid,  1'b0);
        chk("async_out_onehot", bus.out_onehot, 4'b0000);
        chk("async_in_ready",   bus.in_ready,   1'b0);
        exp_q.delete();
        foreach (cnt_m[i]) cnt_m[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 1, 0, a);
        check_all("cnt_after_rst");
        cyc(1, 3, 1, 1, 0, a);
        cyc(0, 0, 0, 1, 0, a);
        check_all("cnt_recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
